psum_drain: RTL and testbench
=============================

# psum_drain

Output-side collector for the PE systolic array. It captures one row-vector of accumulated partial sums from the bottom edge of the array (one `psum_out` per column) into a small FIFO. On the way out it converts each value from PSUM fixed-point to OFM width (round, optional ReLU, saturate). It then serializes the vector column by column over a valid/ready stream to the OFM writer.

## Interface
- PSUM_WIDTH, 16: width of each incoming signed partial sum.
- OFM_WIDTH, 8: width of each outgoing signed OFM value.
- NUM_COL, 4: array columns per captured vector (≥2).
- DEPTH, 4: FIFO depth in vectors (power of 2, ≥2).
- FRAC_SHIFT, 4: arithmetic right shift applied before saturation (0 = no shift, no rounding).
- RELU, 1: 1 = negative results forced to 0.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, highest priority after reset.
- cap_en  in  1  capture strobe for psum_vec.
- psum_vec  in  NUM_COL*PSUM_WIDTH  column c at bits [c*PSUM_WIDTH +: PSUM_WIDTH].
- cap_ready  out  1  FIFO not full.
- ofm_valid  out  1  ofm_data valid.
- ofm_ready  in  1  downstream accepts the beat.
- ofm_data  out  OFM_WIDTH  converted value.
- ofm_col  out  max(1,clog2(NUM_COL))  column index of the current beat.
- ofm_last  out  1  high on the column NUM_COL-1 beat.
- overflow  out  1  sticky: a capture was dropped.
- sat_flag  out  1  sticky: at least one value saturated.

## Operation
- **Push:** when `cap_en && cap_ready`, write psum_vec to the FIFO tail and increment count.
  - `cap_ready = (count != DEPTH)`, combinational from registered state only.
- **Dropped capture:** `cap_en` while full drops the vector, sets `overflow`, and leaves FIFO contents untouched.
- **Push/pop in the same cycle:** allowed when not full; count is unchanged. When full, a pop does not raise `cap_ready` until the following cycle.
- **Conversion, per column, on load into the output bank:**
  - x = sign-extended psum, held in PSUM_WIDTH+1 bits.
  - If FRAC_SHIFT > 0: x = (x + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. This is round-half-up.
  - If RELU and x < 0: x = 0.
  - Clamp x to [-2^(OFM_WIDTH-1), 2^(OFM_WIDTH-1)-1]. Any clamp sets `sat_flag`.
- **Output bank:** NUM_COL registers of OFM_WIDTH, loaded in one cycle when a vector is popped.
- **FSM:**
  - IDLE: if FIFO non-empty, pop the head, load the bank, set col=0, go to SEND.
  - SEND: `ofm_valid=1` and `ofm_data = bank[col]`. On a handshake with col < NUM_COL-1, increment col.
    - On the handshake at col = NUM_COL-1: if FIFO non-empty, pop and load the next vector with col=0 and stay in SEND (no bubble); otherwise go to IDLE.
- `ofm_last = (state==SEND) && (col==NUM_COL-1)`.
- **Backpressure:** while `ofm_valid && !ofm_ready`, ofm_data, ofm_col and ofm_last hold stable.
- **clear:**
  - empties the FIFO (pointers and count to 0) and forces IDLE;
  - drops `ofm_valid` next cycle;
  - clears `overflow` and `sat_flag`;
  - ignores a same-cycle `cap_en`.
- **Reset values:** ofm_valid 0, ofm_data 0, ofm_col 0, ofm_last 0, cap_ready 1, overflow 0, sat_flag 0, FSM IDLE, FIFO empty.
- **Reset mid-stream:** everything returns to the reset values immediately (asynchronous). The partial vector is lost.

## Timing
- **Latency:** cap_en sampled at edge k into an empty drain gives `ofm_valid` high after edge k+1 (first beat visible in cycle k+2).
- **Throughput:** 1 beat/cycle with ofm_ready held high. Sustained capture rate is 1 vector per NUM_COL cycles.
- All outputs are registered or derived only from registers. There is no combinational path from ofm_ready or cap_en to any output.

## Test plan
1. **Basic conversion** (defaults): capture cols 0..3 = 0x0010, 0x0008, 0xFFF0, 0x7FFF, with ofm_ready=1.
   - Expected: ofm_data 1, 1, 0, 127 on consecutive cycles, ofm_col 0..3, ofm_last on the 4th beat only.
   - First beat 2 cycles after capture; sat_flag=1 afterwards.
2. **Backpressure:** same vector, ofm_ready=0 for 5 cycles at col 1.
   - Expected: ofm_data=1, ofm_col=1 held stable all 5 cycles; the sequence resumes unchanged.
3. **Full/overflow:** ofm_ready=0, 6 consecutive captures.
   - Expected: cap_ready low after the 5th capture is accepted (4 in FIFO + 1 in bank); the 6th is dropped and overflow=1.
   - Releasing ready yields exactly 20 beats, then IDLE.
4. **Back-to-back:** two vectors captured 1 cycle apart, ofm_ready=1.
   - Expected: 8 consecutive valid beats with no bubble, ofm_last on beats 4 and 8.
5. **Signed path:** RELU=0, inputs 0xFFD8 and 0x8000.
   - Expected: 0xFE (-2) and 0x80 (-128 saturated); sat_flag set.
6. **Clear/reset mid-stream:**
   - clear asserted at beat 2 of 3 queued vectors: ofm_valid=0 next cycle, cap_ready=1, flags cleared, no further beats.
   - Repeat with rst_n pulsed low asynchronously: same reset state.

Source files
------------

// File: rtl/psum_drain_if.sv
// Capture and OFM stream signals between the systolic array edge, psum_drain and the OFM writer.
// The slave view is the drain itself; the master view is whoever drives captures and ready.
interface psum_drain_if #(
   parameter int PSUM_WIDTH = 16,
   parameter int OFM_WIDTH  = 8,
   parameter int NUM_COL    = 4
);
   localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

   logic                            cap_en;
   logic [NUM_COL*PSUM_WIDTH-1:0]   psum_vec;
   logic                            cap_ready;
   logic                            ofm_valid;
   logic                            ofm_ready;
   logic [OFM_WIDTH-1:0]            ofm_data;
   logic [COL_W-1:0]                ofm_col;
   logic                            ofm_last;

   modport master (
      output cap_en, psum_vec, ofm_ready,
      input  cap_ready, ofm_valid, ofm_data, ofm_col, ofm_last
   );

   modport slave (
      input  cap_en, psum_vec, ofm_ready,
      output cap_ready, ofm_valid, ofm_data, ofm_col, ofm_last
   );
endinterface

// File: rtl/psum_drain.sv
// Captures psum row-vectors into a small FIFO, converts each column to OFM width
// (round-half-up, optional ReLU, saturate) and streams the columns out one per beat.
module psum_drain #(
   parameter int PSUM_WIDTH = 16,
   parameter int OFM_WIDTH  = 8,
   parameter int NUM_COL    = 4,
   parameter int DEPTH      = 4,
   parameter int FRAC_SHIFT = 4,
   parameter int RELU       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   psum_drain_if.slave       bus,
   output logic              overflow,
   output logic              sat_flag
);
   localparam int COL_W  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;
   localparam int VW     = NUM_COL * PSUM_WIDTH;
   localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

   localparam logic [COL_W-1:0]        LAST_COL = COL_W'(NUM_COL - 1);
   localparam logic [CW-1:0]           FULL_CNT = CW'(DEPTH);
   localparam logic signed [PSUM_WIDTH:0] RND     =
      (FRAC_SHIFT > 0) ? ((PSUM_WIDTH+1)'(1) << RND_SH) : '0;
   localparam logic signed [PSUM_WIDTH:0] SAT_MAX =
      (PSUM_WIDTH+1)'((1 << (OFM_WIDTH - 1)) - 1);
   localparam logic signed [PSUM_WIDTH:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                           state_reg, state_next;
   logic [COL_W-1:0]                 col_reg, col_next;
   logic [AW-1:0]                    wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]                    count_reg;
   logic [VW-1:0]                    mem [DEPTH];
   logic [VW-1:0]                    head_vec;
   logic [NUM_COL-1:0][OFM_WIDTH-1:0] conv_vec;
   logic [OFM_WIDTH-1:0]             bank_reg [NUM_COL];
   logic [NUM_COL-1:0]               clamp_vec;
   logic                             overflow_reg, sat_reg;
   logic                             full, not_empty, push, pop;

   assign full      = (count_reg == FULL_CNT);
   assign not_empty = (count_reg != '0);
   assign push      = bus.cap_en && !full && !clear;
   assign head_vec  = mem[rd_ptr_reg];

   // Per-column conversion of the FIFO head, consumed when the head is popped into the bank
   genvar gi;
   generate
      for (gi = 0; gi < NUM_COL; gi++) begin : g_conv
         logic signed [PSUM_WIDTH:0] x_ext;
         logic signed [PSUM_WIDTH:0] x_rnd;
         logic signed [PSUM_WIDTH:0] x_rl;
         logic [OFM_WIDTH-1:0]       x_sat;
         logic                       x_clamp;

         always_comb begin
            x_ext   = {head_vec[gi*PSUM_WIDTH + PSUM_WIDTH - 1],
                       head_vec[gi*PSUM_WIDTH +: PSUM_WIDTH]};
            x_rnd   = (x_ext + RND) >>> FRAC_SHIFT;
            x_clamp = 1'b0;
            if ((RELU != 0) && x_rnd[PSUM_WIDTH]) begin
               x_rl = '0;
            end else begin
               x_rl = x_rnd;
            end
            if (x_rl > SAT_MAX) begin
               x_sat   = SAT_MAX[OFM_WIDTH-1:0];
               x_clamp = 1'b1;
            end else if (x_rl < SAT_MIN) begin
               x_sat   = SAT_MIN[OFM_WIDTH-1:0];
               x_clamp = 1'b1;
            end else begin
               x_sat   = x_rl[OFM_WIDTH-1:0];
            end
         end

         assign conv_vec[gi]  = x_sat;
         assign clamp_vec[gi] = x_clamp;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      pop        = 1'b0;
      if (clear) begin
         state_next = S_IDLE;
         col_next   = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (not_empty) begin
                  pop        = 1'b1;
                  col_next   = '0;
                  state_next = S_SEND;
               end
            end
            S_SEND: begin
               if (bus.ofm_ready) begin
                  if (col_reg != LAST_COL) begin
                     col_next = col_reg + 1'b1;
                  end else if (not_empty) begin
                     // Chain straight into the next vector so the stream has no bubble
                     pop      = 1'b1;
                     col_next = '0;
                  end else begin
                     state_next = S_IDLE;
                     col_next   = '0;
                  end
               end
            end
            default: begin
               state_next = S_IDLE;
               col_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         col_reg   <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (!push && pop) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   // Vector storage carries no reset; only the pointers and count define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= bus.psum_vec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_COL; c++) begin
            bank_reg[c] <= '0;
         end
      end else if (pop) begin
         for (int c = 0; c < NUM_COL; c++) begin
            bank_reg[c] <= conv_vec[c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg <= 1'b0;
         sat_reg      <= 1'b0;
      end else if (clear) begin
         overflow_reg <= 1'b0;
         sat_reg      <= 1'b0;
      end else begin
         if (bus.cap_en && full) begin
            overflow_reg <= 1'b1;
         end
         if (pop && (|clamp_vec)) begin
            sat_reg <= 1'b1;
         end
      end
   end

   assign bus.cap_ready = !full;
   assign bus.ofm_valid = (state_reg == S_SEND);
   assign bus.ofm_data  = bank_reg[col_reg];
   assign bus.ofm_col   = col_reg;
   assign bus.ofm_last  = (state_reg == S_SEND) && (col_reg == LAST_COL);
   assign overflow      = overflow_reg;
   assign sat_flag      = sat_reg;
endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: conversion, backpressure, full/overflow, back-to-back,
// signed path (second instance without ReLU) and clear/reset mid-stream.
module tb_psum_drain;
   localparam int PW = 16;
   localparam int OW = 8;
   localparam int NC = 4;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic clear_a = 1'b0;
   logic clear_b = 1'b0;
   logic ovf_a, sat_a, ovf_b, sat_b;
   int   total = 0;
   int   bad   = 0;

   psum_drain_if #(.PSUM_WIDTH(PW), .OFM_WIDTH(OW), .NUM_COL(NC)) ifa ();
   psum_drain_if #(.PSUM_WIDTH(PW), .OFM_WIDTH(OW), .NUM_COL(NC)) ifb ();

   psum_drain #(
      .PSUM_WIDTH(PW), .OFM_WIDTH(OW), .NUM_COL(NC),
      .DEPTH(4), .FRAC_SHIFT(4), .RELU(1)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .clear(clear_a), .bus(ifa.slave),
      .overflow(ovf_a), .sat_flag(sat_a)
   );

   psum_drain #(
      .PSUM_WIDTH(PW), .OFM_WIDTH(OW), .NUM_COL(NC),
      .DEPTH(4), .FRAC_SHIFT(4), .RELU(0)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .clear(clear_b), .bus(ifb.slave),
      .overflow(ovf_b), .sat_flag(sat_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [NC*PW-1:0] vec4(input logic [15:0] c0, input logic [15:0] c1,
                                               input logic [15:0] c2, input logic [15:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   // Vector n whose column c converts to n*4+c
   function automatic logic [NC*PW-1:0] vec_n(input int n);
      return vec4(16'((n*4 + 0) * 16), 16'((n*4 + 1) * 16),
                  16'((n*4 + 2) * 16), 16'((n*4 + 3) * 16));
   endfunction

   task automatic beat(input string tag, input int c, input int d);
      $display("beat %s col=%0d data=%0h last=%0d", tag, ifa.ofm_col, ifa.ofm_data, ifa.ofm_last);
      chk({tag, "_valid"}, 32'(ifa.ofm_valid), 32'd1);
      chk({tag, "_col"},   32'(ifa.ofm_col),   32'(c));
      chk({tag, "_data"},  32'(ifa.ofm_data),  32'(d));
      chk({tag, "_last"},  32'(ifa.ofm_last),  32'(c == NC - 1));
      cyc();
   endtask

   task automatic pulse_clear_a();
      clear_a = 1'b1;
      cyc();
      clear_a = 1'b0;
   endtask

   task automatic fill_sat_vectors();
      ifa.ofm_ready = 1'b0;
      ifa.psum_vec  = vec4(16'h0010, 16'h0020, 16'h0030, 16'h7FFF);
      ifa.cap_en    = 1'b1;
      repeat (6) cyc();
      ifa.cap_en    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp5 [4];
      int seen;
      exp5 = '{8'hFE, 8'h80, 8'h01, 8'h00};

      ifa.cap_en = 1'b0; ifa.psum_vec = '0; ifa.ofm_ready = 1'b1;
      ifb.cap_en = 1'b0; ifb.psum_vec = '0; ifb.ofm_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(ifa.ofm_valid), 32'd0);
      chk("rst_data",  32'(ifa.ofm_data),  32'd0);
      chk("rst_col",   32'(ifa.ofm_col),   32'd0);
      chk("rst_last",  32'(ifa.ofm_last),  32'd0);
      chk("rst_ready", 32'(ifa.cap_ready), 32'd1);
      chk("rst_ovf",   32'(ovf_a),         32'd0);
      chk("rst_sat",   32'(sat_a),         32'd0);
      rst_n = 1'b1;
      cyc();

      // 1: basic conversion and latency
      ifa.psum_vec = vec4(16'h0010, 16'h0008, 16'hFFF0, 16'h7FFF);
      ifa.cap_en   = 1'b1;
      cyc();
      ifa.cap_en   = 1'b0;
      chk("t1_lat", 32'(ifa.ofm_valid), 32'd0);
      cyc();
      beat("t1", 0, 1);
      beat("t1", 1, 1);
      beat("t1", 2, 0);
      beat("t1", 3, 127);
      chk("t1_idle", 32'(ifa.ofm_valid), 32'd0);
      chk("t1_sat",  32'(sat_a),         32'd1);

      // 2: backpressure at column 1
      pulse_clear_a();
      chk("t2_satclr", 32'(sat_a), 32'd0);
      ifa.psum_vec = vec4(16'h0010, 16'h0008, 16'hFFF0, 16'h7FFF);
      ifa.cap_en   = 1'b1;
      cyc();
      ifa.cap_en   = 1'b0;
      cyc();
      beat("t2", 0, 1);
      ifa.ofm_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t2_hold_valid", 32'(ifa.ofm_valid), 32'd1);
         chk("t2_hold_col",   32'(ifa.ofm_col),   32'd1);
         chk("t2_hold_data",  32'(ifa.ofm_data),  32'd1);
      end
      ifa.ofm_ready = 1'b1;
      beat("t2", 1, 1);
      beat("t2", 2, 0);
      beat("t2", 3, 127);
      chk("t2_idle", 32'(ifa.ofm_valid), 32'd0);

      // 3: full FIFO, dropped sixth capture, then 20 beats
      pulse_clear_a();
      ifa.ofm_ready = 1'b0;
      for (int n = 0; n < 6; n++) begin
         chk("t3_capready", 32'(ifa.cap_ready), 32'(n < 5));
         ifa.psum_vec = vec_n(n);
         ifa.cap_en   = 1'b1;
         cyc();
      end
      ifa.cap_en = 1'b0;
      chk("t3_full", 32'(ifa.cap_ready), 32'd0);
      chk("t3_ovf",  32'(ovf_a),         32'd1);
      ifa.ofm_ready = 1'b1;
      for (int b = 0; b < 20; b++) begin
         beat("t3", b % 4, b);
      end
      chk("t3_idle",  32'(ifa.ofm_valid), 32'd0);
      chk("t3_sat",   32'(sat_a),         32'd0);
      chk("t3_ready", 32'(ifa.cap_ready), 32'd1);

      // 4: back-to-back vectors, no bubble
      pulse_clear_a();
      ifa.psum_vec = vec4(16'd16, 16'd32, 16'd48, 16'd64);
      ifa.cap_en   = 1'b1;
      cyc();
      ifa.psum_vec = vec4(16'd80, 16'd96, 16'd112, 16'd128);
      cyc();
      ifa.cap_en   = 1'b0;
      for (int b = 0; b < 8; b++) begin
         beat("t4", b % 4, b + 1);
      end
      chk("t4_idle", 32'(ifa.ofm_valid), 32'd0);

      // 5: signed path without ReLU
      chk("t5_sat0", 32'(sat_b), 32'd0);
      ifb.psum_vec = vec4(16'hFFD8, 16'h8000, 16'h0010, 16'h0000);
      ifb.cap_en   = 1'b1;
      cyc();
      ifb.cap_en   = 1'b0;
      cyc();
      for (int c = 0; c < 4; c++) begin
         $display("beat t5 col=%0d data=%0h", ifb.ofm_col, ifb.ofm_data);
         chk("t5_valid", 32'(ifb.ofm_valid), 32'd1);
         chk("t5_col",   32'(ifb.ofm_col),   32'(c));
         chk("t5_data",  32'(ifb.ofm_data),  32'(exp5[c]));
         cyc();
      end
      chk("t5_sat", 32'(sat_b), 32'd1);

      // 6a: clear mid-stream with a same-cycle capture
      pulse_clear_a();
      fill_sat_vectors();
      chk("t6_pre_ovf", 32'(ovf_a), 32'd1);
      chk("t6_pre_sat", 32'(sat_a), 32'd1);
      ifa.ofm_ready = 1'b1;
      beat("t6", 0, 1);
      clear_a    = 1'b1;
      ifa.cap_en = 1'b1;
      cyc();
      clear_a    = 1'b0;
      ifa.cap_en = 1'b0;
      chk("t6_valid", 32'(ifa.ofm_valid), 32'd0);
      chk("t6_ready", 32'(ifa.cap_ready), 32'd1);
      chk("t6_ovf",   32'(ovf_a),         32'd0);
      chk("t6_sat",   32'(sat_a),         32'd0);
      seen = 0;
      repeat (8) begin
         if (ifa.ofm_valid) seen++;
         cyc();
      end
      chk("t6_nobeats", 32'(seen), 32'd0);

      // 6b: asynchronous reset mid-stream
      fill_sat_vectors();
      ifa.ofm_ready = 1'b1;
      beat("t6r", 0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6r_valid", 32'(ifa.ofm_valid), 32'd0);
      chk("t6r_data",  32'(ifa.ofm_data),  32'd0);
      chk("t6r_col",   32'(ifa.ofm_col),   32'd0);
      chk("t6r_last",  32'(ifa.ofm_last),  32'd0);
      chk("t6r_ready", 32'(ifa.cap_ready), 32'd1);
      chk("t6r_ovf",   32'(ovf_a),         32'd0);
      chk("t6r_sat",   32'(sat_a),         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         cyc();
         if (ifa.ofm_valid) seen++;
      end
      chk("t6r_nobeats", 32'(seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
